// File: rtl/ilock_ctrl.sv
// ilock_ctrl: pipeline interlock controller for the ARM9 Thumb core.
// Resolves hazards that operand forwarding cannot: load-use dependencies,
// data-memory wait states and multi-cycle multiplies. Drives per-stage
// stall controls for IF/ID/EX/MEM and the EX bubble insert.
//
// Optional feature macro: ILOCK_MUL_EN
//   defined   - MULT state and multiply cycle counter are built.
//   undefined - D_MUL / D_MUL_CYC are ignored, state 3 is unreachable.
//
// Handshake/timing contract: all stall and bubble outputs are combinational
// from the registered state and same-cycle inputs (zero-latency interlock);
// a stage whose STALL_x is 1 holds its pipeline register for that cycle.
// All outputs are forced low while RST is asserted.
module ilock_ctrl #(
    parameter int MUL_CNT_W = 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [3:0]           D_RB,
    input  logic [3:0]           D_RC,
    input  logic                 D_VALID_B,
    input  logic                 D_VALID_C,
    input  logic                 D_MUL,
    input  logic [MUL_CNT_W-1:0] D_MUL_CYC,
    input  logic [3:0]           E_RA1,
    input  logic                 E_VALID1,
    input  logic                 E_LOAD,
    input  logic                 M_MEM,
    input  logic                 DMEM_RDY,
    input  logic                 FLUSH,
    output logic                 STALL_F,
    output logic                 STALL_D,
    output logic                 STALL_E,
    output logic                 STALL_M,
    output logic                 BUBBLE_E,
    output logic [1:0]           ILOCK_ST
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        LDUSE = 2'd1,
        MWAIT = 2'd2,
        MULT  = 2'd3
    } state_t;

    state_t state, state_nx;
    state_t ret_st, ret_nx;

    logic ld_hz;
    logic mw_hz;
    logic sf, sd, se, sm, be;

`ifdef ILOCK_MUL_EN
    logic [MUL_CNT_W-1:0] cnt, cnt_nx;
`else
    // Multiply inputs have no function in this build.
    logic unused_mul;
    assign unused_mul = ^{D_MUL, D_MUL_CYC};
`endif

    assign ld_hz = E_LOAD & E_VALID1 &
                   ((D_VALID_B & (D_RB == E_RA1)) | (D_VALID_C & (D_RC == E_RA1)));
    assign mw_hz = M_MEM & ~DMEM_RDY;

    // Next-state and stall decode; memory wait outranks everything.
    always_comb begin
        sf       = 1'b0;
        sd       = 1'b0;
        se       = 1'b0;
        sm       = 1'b0;
        be       = 1'b0;
        state_nx = state;
        ret_nx   = ret_st;
`ifdef ILOCK_MUL_EN
        cnt_nx   = cnt;
`endif
        if (mw_hz) begin
            // Full freeze; remember where to resume, multiply counter held.
            sf       = 1'b1;
            sd       = 1'b1;
            se       = 1'b1;
            sm       = 1'b1;
            state_nx = MWAIT;
            if (state != MWAIT) ret_nx = state;
        end else begin
            unique case (state)
                // LDUSE re-evaluates hazards against the instruction now in EX,
                // so it shares the RUN decode.
                RUN, LDUSE: begin
                    if (ld_hz && !FLUSH) begin
                        sf       = 1'b1;
                        sd       = 1'b1;
                        be       = 1'b1;
                        state_nx = LDUSE;
                    end else begin
                        state_nx = RUN;
`ifdef ILOCK_MUL_EN
                        if (D_MUL && (D_MUL_CYC > MUL_CNT_W'(1)) && !FLUSH) begin
                            state_nx = MULT;
                            cnt_nx   = D_MUL_CYC - MUL_CNT_W'(1);
                        end
`endif
                    end
                end
                MWAIT: begin
                    // Memory ready: stalls already dropped, resume saved state.
                    state_nx = ret_st;
                end
                MULT: begin
`ifdef ILOCK_MUL_EN
                    sf = 1'b1;
                    sd = 1'b1;
                    se = 1'b1;
                    // Counter value 1 marks the final stall cycle.
                    if (cnt <= MUL_CNT_W'(1)) begin
                        state_nx = RUN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt - MUL_CNT_W'(1);
                    end
`else
                    state_nx = RUN;
`endif
                end
                default: state_nx = RUN;
            endcase
        end
    end

    // State, return state and multiply counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= RUN;
            ret_st <= RUN;
`ifdef ILOCK_MUL_EN
            cnt    <= '0;
`endif
        end else begin
            state  <= state_nx;
            ret_st <= ret_nx;
`ifdef ILOCK_MUL_EN
            cnt    <= cnt_nx;
`endif
        end
    end

    // Outputs drop asynchronously while reset is held.
    assign STALL_F  = sf & ~RST;
    assign STALL_D  = sd & ~RST;
    assign STALL_E  = se & ~RST;
    assign STALL_M  = sm & ~RST;
    assign BUBBLE_E = be & ~RST;
    assign ILOCK_ST = state;

endmodule

// File: tb/tb_ilock_ctrl.sv
// tb_ilock_ctrl: directed-vector bench for ilock_ctrl.
// Observed vector is {STALL_F, STALL_D, STALL_E, STALL_M, BUBBLE_E, ILOCK_ST}.
module tb_ilock_ctrl;

    localparam int MUL_CNT_W = 3;

    // Stall field patterns {F, D, E, M, B}
    localparam logic [4:0] S_NONE = 5'b00000;
    localparam logic [4:0] S_LD   = 5'b11001;
    localparam logic [4:0] S_MW   = 5'b11110;
    localparam logic [4:0] S_MUL  = 5'b11100;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_LDUSE = 2'd1;
    localparam logic [1:0] ST_MWAIT = 2'd2;
    localparam logic [1:0] ST_MULT  = 2'd3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           d_rb, d_rc, e_ra1;
    logic                 d_valid_b, d_valid_c, d_mul;
    logic [MUL_CNT_W-1:0] d_mul_cyc;
    logic                 e_valid1, e_load, m_mem, dmem_rdy, flush;
    logic                 stall_f, stall_d, stall_e, stall_m, bubble_e;
    logic [1:0]           ilock_st;
    logic [6:0]           obs;

    int n_tests = 0;
    int n_fail  = 0;

    ilock_ctrl #(.MUL_CNT_W(MUL_CNT_W)) dut (
        .CLK       (clk),
        .RST       (rst),
        .D_RB      (d_rb),
        .D_RC      (d_rc),
        .D_VALID_B (d_valid_b),
        .D_VALID_C (d_valid_c),
        .D_MUL     (d_mul),
        .D_MUL_CYC (d_mul_cyc),
        .E_RA1     (e_ra1),
        .E_VALID1  (e_valid1),
        .E_LOAD    (e_load),
        .M_MEM     (m_mem),
        .DMEM_RDY  (dmem_rdy),
        .FLUSH     (flush),
        .STALL_F   (stall_f),
        .STALL_D   (stall_d),
        .STALL_E   (stall_e),
        .STALL_M   (stall_m),
        .BUBBLE_E  (bubble_e),
        .ILOCK_ST  (ilock_st)
    );

    assign obs = {stall_f, stall_d, stall_e, stall_m, bubble_e, ilock_st};

    // Clock
    always #5 clk = ~clk;

    function automatic logic [6:0] ev(input logic [4:0] s, input logic [1:0] st);
        return {s, st};
    endfunction

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check mid-cycle, then advance one clock.
    task automatic step(input string tag, input logic [6:0] exp);
        #3;
        check(tag, obs, exp);
        tick();
    endtask

    task automatic idle();
        d_rb      = 4'd0;
        d_rc      = 4'd0;
        d_valid_b = 1'b0;
        d_valid_c = 1'b0;
        d_mul     = 1'b0;
        d_mul_cyc = '0;
        e_ra1     = 4'd0;
        e_valid1  = 1'b0;
        e_load    = 1'b0;
        m_mem     = 1'b0;
        dmem_rdy  = 1'b0;
        flush     = 1'b0;
    endtask

    // EX holds a load to r3; ID reads r3 on RB.
    task automatic ld_r3_on_b();
        e_load    = 1'b1;
        e_valid1  = 1'b1;
        e_ra1     = 4'd3;
        d_rb      = 4'd3;
        d_valid_b = 1'b1;
    endtask

    initial begin
        // Reset with a memory wait pending: outputs must still read 0.
        idle();
        rst      = 1'b1;
        m_mem    = 1'b1;
        dmem_rdy = 1'b0;
        #2;
        check("reset_outputs", obs, ev(S_NONE, ST_RUN));
        tick();
        tick();
        idle();
        rst = 1'b0;
        step("post_reset_idle", ev(S_NONE, ST_RUN));

        // Load-use on RB: one bubble cycle, LDUSE, then RUN.
        ld_r3_on_b();
        step("lduse_stall", ev(S_LD, ST_RUN));
        idle();
        step("lduse_state", ev(S_NONE, ST_LDUSE));
        step("lduse_back_run", ev(S_NONE, ST_RUN));

        // Same load, ID reads r4 on RB and r3 on RC with RC not valid.
        ld_r3_on_b();
        d_rb      = 4'd4;
        d_rc      = 4'd3;
        d_valid_c = 1'b0;
        step("ld_rc_invalid", ev(S_NONE, ST_RUN));

        // RC now valid: hazard through RC.
        d_valid_c = 1'b1;
        step("ld_rc_valid", ev(S_LD, ST_RUN));
        idle();
        step("ld_rc_lduse", ev(S_NONE, ST_LDUSE));

        // Matching register but EX destination not valid.
        ld_r3_on_b();
        e_valid1 = 1'b0;
        step("ld_e_invalid", ev(S_NONE, ST_RUN));

        // Matching register but EX is not a load.
        ld_r3_on_b();
        e_load = 1'b0;
        step("ld_not_load", ev(S_NONE, ST_RUN));

        // Memory wait of 3 cycles, stalls drop when DMEM_RDY rises.
        idle();
        m_mem = 1'b1;
        step("mw_c1", ev(S_MW, ST_RUN));
        step("mw_c2", ev(S_MW, ST_MWAIT));
        step("mw_c3", ev(S_MW, ST_MWAIT));
        dmem_rdy = 1'b1;
        step("mw_rdy", ev(S_NONE, ST_MWAIT));
        idle();
        step("mw_back_run", ev(S_NONE, ST_RUN));

        // Memory wait outranks a simultaneous load-use.
        ld_r3_on_b();
        m_mem = 1'b1;
        step("mw_over_ld", ev(S_MW, ST_RUN));
        dmem_rdy = 1'b1;
        e_load   = 1'b0;
        step("mw_over_ld_rdy", ev(S_NONE, ST_MWAIT));
        idle();
        step("mw_over_ld_run", ev(S_NONE, ST_RUN));

        // Memory wait arriving in LDUSE returns to LDUSE.
        ld_r3_on_b();
        step("lm_ld", ev(S_LD, ST_RUN));
        idle();
        m_mem = 1'b1;
        step("lm_mw_in_lduse", ev(S_MW, ST_LDUSE));
        dmem_rdy = 1'b1;
        step("lm_rdy", ev(S_NONE, ST_MWAIT));
        idle();
        step("lm_ret_lduse", ev(S_NONE, ST_LDUSE));
        step("lm_run", ev(S_NONE, ST_RUN));

        // Flush clears a pending load-use.
        ld_r3_on_b();
        flush = 1'b1;
        step("flush_ld", ev(S_NONE, ST_RUN));
        idle();
        step("flush_stays_run", ev(S_NONE, ST_RUN));

        // Multiply tests.
        d_mul     = 1'b1;
        d_mul_cyc = 3'd4;
`ifdef ILOCK_MUL_EN
        step("mul4_issue", ev(S_NONE, ST_RUN));
        idle();
        step("mul4_s1", ev(S_MUL, ST_MULT));
        step("mul4_s2", ev(S_MUL, ST_MULT));
        step("mul4_s3", ev(S_MUL, ST_MULT));
        step("mul4_done", ev(S_NONE, ST_RUN));

        d_mul     = 1'b1;
        d_mul_cyc = 3'd1;
        step("mul1_issue", ev(S_NONE, ST_RUN));
        idle();
        step("mul1_no_stall", ev(S_NONE, ST_RUN));

        // Multiply with a flush does not start.
        d_mul     = 1'b1;
        d_mul_cyc = 3'd4;
        flush     = 1'b1;
        step("mul_flush_issue", ev(S_NONE, ST_RUN));
        idle();
        step("mul_flush_none", ev(S_NONE, ST_RUN));

        // 2-cycle memory wait in the 2nd MULT cycle freezes the counter.
        d_mul     = 1'b1;
        d_mul_cyc = 3'd4;
        step("mm_issue", ev(S_NONE, ST_RUN));
        idle();
        step("mm_s1", ev(S_MUL, ST_MULT));
        m_mem = 1'b1;
        step("mm_mw1", ev(S_MW, ST_MULT));
        step("mm_mw2", ev(S_MW, ST_MWAIT));
        dmem_rdy = 1'b1;
        step("mm_rdy", ev(S_NONE, ST_MWAIT));
        idle();
        step("mm_s2", ev(S_MUL, ST_MULT));
        step("mm_s3", ev(S_MUL, ST_MULT));
        step("mm_done", ev(S_NONE, ST_RUN));

        // Reset in MULT clears outputs immediately.
        d_mul     = 1'b1;
        d_mul_cyc = 3'd4;
        step("rm_issue", ev(S_NONE, ST_RUN));
        idle();
        #2;
        check("rm_in_mult", obs, ev(S_MUL, ST_MULT));
        rst = 1'b1;
        #1;
        check("rm_reset", obs, ev(S_NONE, ST_RUN));
        tick();
        rst = 1'b0;
        step("rm_after", ev(S_NONE, ST_RUN));
`else
        step("mul_disabled_issue", ev(S_NONE, ST_RUN));
        idle();
        step("mul_disabled_none", ev(S_NONE, ST_RUN));
        step("mul_disabled_none2", ev(S_NONE, ST_RUN));
`endif

        // Reset during a memory wait drops the freeze immediately.
        idle();
        m_mem = 1'b1;
        step("rw_c1", ev(S_MW, ST_RUN));
        #2;
        check("rw_in_mwait", obs, ev(S_MW, ST_MWAIT));
        rst = 1'b1;
        #1;
        check("rw_reset", obs, ev(S_NONE, ST_RUN));
        tick();
        idle();
        rst = 1'b0;
        step("rw_after", ev(S_NONE, ST_RUN));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
